// File: rtl/fft_inv_butterfly.sv
// Radix-2 inverse butterfly. It takes the forward butterfly's (sum, diff) pair and
// rebuilds r = (sum+diff)/2 and i = (sum-diff)/2 through a 2-stage valid/ready pipeline.
// It also provides parity error flagging, a sticky ERR state and saturating counters.
module fft_inv_butterfly #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUTTERFLY_ID = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clr_err,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] sum_in,
    input  logic [DATA_WIDTH-1:0] diff_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] real_out,
    output logic [DATA_WIDTH-1:0] imag_out,
    output logic                  parity_err,
    output logic [1:0]            state_out,
    output logic [31:0]           sample_cnt,
    output logic [15:0]           err_cnt,
    output logic [7:0]            bf_id
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10,
        ERR  = 2'b11
    } state_t;

    state_t         state;
    logic           adv;
    logic           in_fire;
    logic           out_fire;
    logic [W:0]     tr;
    logic [W:0]     ti;
    logic           s1_vld;
    logic [W-1:0]   s1_real;
    logic [W-1:0]   s1_imag;
    logic           s1_perr;

    // Whole pipeline moves together whenever the output slot is free or being taken.
    // rst_n gates in_ready so nothing is offered to upstream while held in reset.
    assign adv      = !out_valid || out_ready;
    assign in_ready = enable && adv && rst_n;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // One extra bit keeps sum+diff / sum-diff exact; dropping bit 0 is the arithmetic /2.
    // tr[0] == ti[0] always, and a set bit means no integer (r, i) pair produces this input.
    assign tr = {sum_in[W-1], sum_in} + {diff_in[W-1], diff_in};
    assign ti = {sum_in[W-1], sum_in} - {diff_in[W-1], diff_in};

    assign state_out = state;
    assign bf_id     = 8'(BUTTERFLY_ID);

    // Stage 1: capture the arithmetic result of an accepted beat, or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_real <= '0;
            s1_imag <= '0;
            s1_perr <= 1'b0;
        end else if (adv) begin
            s1_vld <= in_fire;
            if (in_fire) begin
                s1_real <= tr[W:1];
                s1_imag <= ti[W:1];
                s1_perr <= tr[0];
            end
        end
    end

    // Stage 2 / output register: data holds its last value across bubbles and stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            real_out   <= '0;
            imag_out   <= '0;
            parity_err <= 1'b0;
        end else if (adv) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                real_out   <= s1_real;
                imag_out   <= s1_imag;
                parity_err <= s1_perr;
            end
        end
    end

    // Saturating counters of delivered beats and of delivered parity-error beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
        end else if (out_fire) begin
            if (sample_cnt != '1)
                sample_cnt <= sample_cnt + 32'd1;
            if (parity_err && err_cnt != '1)
                err_cnt <= err_cnt + 16'd1;
        end
    end

    // Status FSM. It only observes the datapath and never stalls it. An error beat wins
    // over everything, including a clr_err pulse in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (out_fire && parity_err) begin
            state <= ERR;
        end else begin
            case (state)
                ERR:     if (clr_err) state <= IDLE;
                IDLE:    if (s1_vld || out_valid) state <= CALC;
                CALC:    if (!s1_vld && !out_valid) state <= DONE;
                DONE:    state <= (s1_vld || out_valid) ? CALC : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_inv_butterfly.sv
// Directed bench for fft_inv_butterfly: vector table plus hand-written multi-cycle sequences.
module tb_fft_inv_butterfly;
    localparam int W = 32;
    localparam logic [1:0] S_IDLE = 2'b00, S_CALC = 2'b01, S_DONE = 2'b10, S_ERR = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic         clr_err = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] sum_in = '0;
    logic [W-1:0] diff_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] real_out;
    logic [W-1:0] imag_out;
    logic         parity_err;
    logic [1:0]   state_out;
    logic [31:0]  sample_cnt;
    logic [15:0]  err_cnt;
    logic [7:0]   bf_id;

    fft_inv_butterfly #(.DATA_WIDTH(W), .BUTTERFLY_ID(3)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clr_err(clr_err),
        .in_valid(in_valid), .in_ready(in_ready), .sum_in(sum_in), .diff_in(diff_in),
        .out_valid(out_valid), .out_ready(out_ready), .real_out(real_out),
        .imag_out(imag_out), .parity_err(parity_err), .state_out(state_out),
        .sample_cnt(sample_cnt), .err_cnt(err_cnt), .bf_id(bf_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] d;
        logic [W-1:0] r;
        logic [W-1:0] i;
        logic         p;
    } vec_t;

    typedef struct {
        logic [W-1:0] r;
        logic [W-1:0] i;
        logic         p;
        int           c;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    exp_cnt = 0;
    int    exp_err = 0;
    beat_t q[$];
    vec_t  tv[12];

    always @(posedge clk) cyc++;

    // Output monitor: records every beat that will be taken at the next rising edge.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready)
            q.push_back('{r: real_out, i: imag_out, p: parity_err, c: cyc});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [W-1:0] s, input logic [W-1:0] d);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; sum_in = s; diff_in = d;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (in_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        else begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready never rose for sum=%0h", s);
            in_valid = 1'b0;
        end
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_beat(input string name, input int idx, input vec_t v);
        if (q.size() > idx) begin
            chk({name, "_real"}, q[idx].r, v.r);
            chk({name, "_imag"}, q[idx].i, v.i);
            chk({name, "_perr"}, q[idx].p, v.p);
        end else begin
            chk({name, "_present"}, q.size(), idx + 1);
        end
    endtask

    task automatic clr_pulse();
        @(negedge clk); clr_err = 1'b1;
        @(negedge clk); clr_err = 1'b0;
    endtask

    initial begin
        logic [1:0]   st[14];
        logic [W-1:0] hr, hi;
        int           dn, di, bad;

        tv[0]  = '{32'h2,        32'hFFFFFFFC, 32'hFFFFFFFF, 32'h3,        1'b0};
        tv[1]  = '{32'h8,        32'h2,        32'h5,        32'h3,        1'b0};
        tv[2]  = '{32'h0,        32'h0,        32'h0,        32'h0,        1'b0};
        tv[3]  = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'hFFFFFFFC, 32'hFFFFFFFE, 1'b0};
        tv[4]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0,        1'b0};
        tv[5]  = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h0,        1'b0};
        tv[6]  = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1};
        tv[7]  = '{32'h7,        32'h2,        32'h4,        32'h2,        1'b1};
        tv[8]  = '{32'h64,       32'hFFFFFF9C, 32'h0,        32'h64,       1'b0};
        tv[9]  = '{32'h3,        32'h0,        32'h1,        32'h1,        1'b1};
        tv[10] = '{32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
        tv[11] = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1};

        // Reset state
        enable = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_state", state_out, S_IDLE);
        chk("rst_sample_cnt", sample_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_real", real_out, 0);
        chk("rst_perr", parity_err, 0);
        chk("bf_id", bf_id, 3);
        @(negedge clk); rst_n = 1'b1;

        // Test 1: single beat, exact latency
        q.delete();
        @(negedge clk);
        in_valid = 1'b1; sum_in = 32'd8; diff_in = 32'd2;
        #1 chk("t1_in_ready", in_ready, 1);
        @(negedge clk); in_valid = 1'b0;
        #2 chk("t1_valid_1cyc", out_valid, 0);
        @(negedge clk);
        #2 chk("t1_valid_2cyc", out_valid, 1);
        chk("t1_real", real_out, 5);
        chk("t1_imag", imag_out, 3);
        chk("t1_perr", parity_err, 0);
        @(negedge clk);
        exp_cnt = 1;
        #2 chk("t1_sample_cnt", sample_cnt, exp_cnt);
        repeat (3) @(negedge clk);
        #2 chk("t1_state_idle", state_out, S_IDLE);

        // Test 2: 4 back-to-back beats with state trace
        q.delete();
        fork
            begin
                for (int k = 0; k < 4; k++) send_beat(tv[k].s, tv[k].d);
                idle_in();
            end
            begin
                for (int k = 0; k < 14; k++) begin
                    @(negedge clk); #3;
                    st[k] = state_out;
                end
            end
        join
        dn = 0; di = 0;
        for (int k = 0; k < 14; k++) if (st[k] == S_DONE) begin dn++; di = k; end
        chk("t2_start_idle", st[0], S_IDLE);
        chk("t2_done_once", dn, 1);
        if (di > 0 && di < 13) begin
            chk("t2_before_done", st[di-1], S_CALC);
            chk("t2_after_done", st[di+1], S_IDLE);
        end
        chk("t2_end_idle", st[13], S_IDLE);
        chk("t2_beats", q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk_beat("t2", k, tv[k]);
            if (k > 0 && q.size() > k) chk("t2_consecutive", q[k].c - q[0].c, k);
        end
        exp_cnt += 4;
        chk("t2_sample_cnt", sample_cnt, exp_cnt);

        // Test 3: 6-beat stream with a 3-cycle downstream stall
        q.delete();
        fork
            begin
                for (int k = 0; k < 6; k++) send_beat(tv[k].s, tv[k].d);
                idle_in();
            end
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b0;
                #2;
                chk("t3_stall_in_ready", in_ready, 0);
                chk("t3_stall_valid", out_valid, 1);
                hr = real_out; hi = imag_out;
                for (int j = 0; j < 2; j++) begin
                    @(negedge clk); #2;
                    chk("t3_stall_in_ready", in_ready, 0);
                    chk("t3_hold_valid", out_valid, 1);
                    chk("t3_hold_real", real_out, hr);
                    chk("t3_hold_imag", imag_out, hi);
                end
                @(negedge clk); out_ready = 1'b1;
            end
        join
        repeat (8) @(negedge clk);
        chk("t3_beats", q.size(), 6);
        for (int k = 0; k < 6; k++) chk_beat("t3", k, tv[k]);
        exp_cnt += 6;
        #2 chk("t3_sample_cnt", sample_cnt, exp_cnt);

        // Test 4: unreachable pair -> ERR, sticky, cleared by clr_err
        q.delete();
        send_beat(tv[7].s, tv[7].d);
        idle_in();
        repeat (4) @(negedge clk);
        chk_beat("t4", 0, tv[7]);
        exp_cnt += 1; exp_err += 1;
        #2 chk("t4_state_err", state_out, S_ERR);
        chk("t4_err_cnt", err_cnt, exp_err);
        repeat (2) @(negedge clk);
        #2 chk("t4_err_sticky", state_out, S_ERR);
        clr_pulse();
        #2 chk("t4_cleared", state_out, S_IDLE);

        // Test 5: enable drops with 2 beats in flight
        q.delete();
        send_beat(tv[1].s, tv[1].d);
        send_beat(tv[2].s, tv[2].d);
        @(negedge clk);
        enable = 1'b0; sum_in = 32'd100; diff_in = 32'd0;
        bad = 0; dn = 0;
        for (int k = 0; k < 8; k++) begin
            #1 if (in_ready) bad++;
            #2 if (state_out == S_DONE) dn++;
            @(negedge clk);
        end
        chk("t5_in_ready_low", bad, 0);
        chk("t5_beats", q.size(), 2);
        chk_beat("t5a", 0, tv[1]);
        chk_beat("t5b", 1, tv[2]);
        chk("t5_done_once", dn, 1);
        #2 chk("t5_end_idle", state_out, S_IDLE);
        in_valid = 1'b0; enable = 1'b1;
        exp_cnt += 2;

        // Vector table: one isolated beat per entry
        for (int v = 0; v < 12; v++) begin
            q.delete();
            send_beat(tv[v].s, tv[v].d);
            idle_in();
            repeat (4) @(negedge clk);
            chk_beat($sformatf("vec%0d", v), 0, tv[v]);
            exp_cnt += 1;
            if (tv[v].p) begin
                exp_err += 1;
                #2 chk($sformatf("vec%0d_state_err", v), state_out, S_ERR);
                clr_pulse();
            end
            #2 chk($sformatf("vec%0d_state_idle", v), state_out, S_IDLE);
        end
        chk("tbl_sample_cnt", sample_cnt, exp_cnt);
        chk("tbl_err_cnt", err_cnt, exp_err);

        // Test 6: reset with 2 beats in flight
        q.delete();
        send_beat(tv[1].s, tv[1].d);
        send_beat(tv[2].s, tv[2].d);
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        #2;
        chk("t6_valid", out_valid, 0);
        chk("t6_sample_cnt", sample_cnt, 0);
        chk("t6_err_cnt", err_cnt, 0);
        chk("t6_real", real_out, 0);
        chk("t6_state", state_out, S_IDLE);
        @(negedge clk); rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #2;
            if (out_valid) bad++;
        end
        chk("t6_no_output", bad, 0);
        chk("t6_no_beats", q.size(), 0);
        chk("t6_cnt_zero", sample_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
